// File: rtl/alu_control_sequencer_if.sv
// Signal bundle between the control-step sequencer and the datapath it drives.
// Optional SEQ_SINGLE_STEP_EN adds the step input used to gate state advance.
interface alu_control_sequencer_if #(
    parameter int NREG = 16
);
    logic            start;
    logic [31:0]     IR;
`ifdef SEQ_SINGLE_STEP_EN
    logic            step;
`endif
    logic            busy;
    logic            done;
    logic            illegal;
    logic [NREG-1:0] Rout;
    logic [NREG-1:0] Rin;
    logic            PCin, IncPC, MARin, MDRin, Read, MDRout, IRin;
    logic            Yin, Zin, Zlowout, HIin, LOin;
    logic            AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
    logic [2:0]      state_dbg;

    modport master (
        output start, IR,
`ifdef SEQ_SINGLE_STEP_EN
        output step,
`endif
        input  busy, done, illegal, Rout, Rin,
        input  PCin, IncPC, MARin, MDRin, Read, MDRout, IRin,
        input  Yin, Zin, Zlowout, HIin, LOin,
        input  AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
        input  state_dbg
    );

    modport slave (
        input  start, IR,
`ifdef SEQ_SINGLE_STEP_EN
        input  step,
`endif
        output busy, done, illegal, Rout, Rin,
        output PCin, IncPC, MARin, MDRin, Read, MDRout, IRin,
        output Yin, Zin, Zlowout, HIin, LOin,
        output AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
        output state_dbg
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// Hardwired T0-T5 control-step generator for register-to-register ALU instructions.
// Define SEQ_SINGLE_STEP_EN to gate every T-state transition on the step input.
module alu_control_sequencer #(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_control_sequencer_if.slave bus
);
    // Handshake: start is sampled only in IDLE; busy is high in every T-state and
    // done pulses in the write-back step, after which the sequencer is back in IDLE.
    typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5} state_t;
    typedef enum logic [1:0] {C_ILL, C_3OP, C_MD, C_UN} cls_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_SHRA = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);

    function automatic cls_t classify(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:   return C_3OP;
            OP_MUL, OP_DIV:                  return C_MD;
            OP_NEG, OP_NOT:                  return C_UN;
            default:                         return C_ILL;
        endcase
    endfunction

    // One-hot in the order {AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT}.
    function automatic logic [12:0] alu_select(input logic [OPW-1:0] op);
        case (op)
            OP_AND:  return 13'h1000;
            OP_OR:   return 13'h0800;
            OP_ADD:  return 13'h0400;
            OP_SUB:  return 13'h0200;
            OP_MUL:  return 13'h0100;
            OP_DIV:  return 13'h0080;
            OP_SHR:  return 13'h0040;
            OP_SHRA: return 13'h0020;
            OP_SHL:  return 13'h0010;
            OP_ROR:  return 13'h0008;
            OP_ROL:  return 13'h0004;
            OP_NEG:  return 13'h0002;
            OP_NOT:  return 13'h0001;
            default: return 13'h0000;
        endcase
    endfunction

    function automatic logic [NREG-1:0] onehot(input logic [3:0] r);
        return NREG'(1) << r;
    endfunction

    state_t         state_q, state_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic [3:0]     ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;

    logic [OPW-1:0] ir_op;
    logic [3:0]     ir_ra, ir_rb, ir_rc;
    logic           advance;
    cls_t           ir_cls, lat_cls;
    logic           unused_ir_bits;

    assign ir_op          = bus.IR[31 -: OPW];
    assign ir_ra          = bus.IR[26:23];
    assign ir_rb          = bus.IR[22:19];
    assign ir_rc          = bus.IR[18:15];
    assign unused_ir_bits = ^bus.IR[14:0];
    assign ir_cls         = classify(ir_op);
    assign lat_cls        = classify(opcode_q);

`ifdef SEQ_SINGLE_STEP_EN
    assign advance = bus.step;
`else
    assign advance = 1'b1;
`endif

    logic            busy, done, illegal;
    logic [NREG-1:0] rout, rin;
    logic            pc_in, inc_pc, mar_in, mdr_in, read, mdr_out, ir_in;
    logic            y_in, z_in, zlow_out, hi_in, lo_in;
    logic [12:0]     alu_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rc_d     = rc_q;
        busy     = 1'b1;
        done     = 1'b0;
        illegal  = 1'b0;
        rout     = '0;
        rin      = '0;
        pc_in    = 1'b0;
        inc_pc   = 1'b0;
        mar_in   = 1'b0;
        mdr_in   = 1'b0;
        read     = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        zlow_out = 1'b0;
        hi_in    = 1'b0;
        lo_in    = 1'b0;
        alu_sel  = '0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.start) state_d = S_T0;
            end
            S_T0: begin
                inc_pc = 1'b1;
                pc_in  = 1'b1;
                mar_in = 1'b1;
                if (advance) state_d = S_T1;
            end
            S_T1: begin
                read   = 1'b1;
                mdr_in = 1'b1;
                if (advance) state_d = S_T2;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                if (advance) state_d = S_T3;
            end
            // First operand step decodes straight from IR; fields are captured on exit.
            S_T3: begin
                case (ir_cls)
                    C_3OP: begin rout = onehot(ir_rb); y_in = 1'b1; end
                    C_MD:  begin rout = onehot(ir_ra); y_in = 1'b1; end
                    C_UN:  begin rout = onehot(ir_rb); alu_sel = alu_select(ir_op); z_in = 1'b1; end
                    default: illegal = 1'b1;
                endcase
                if (advance) begin
                    opcode_d = ir_op;
                    ra_d     = ir_ra;
                    rb_d     = ir_rb;
                    rc_d     = ir_rc;
                    state_d  = (ir_cls == C_ILL) ? S_IDLE : S_T4;
                end
            end
            S_T4: begin
                case (lat_cls)
                    C_3OP: begin rout = onehot(rc_q); alu_sel = alu_select(opcode_q); z_in = 1'b1; end
                    C_MD:  begin rout = onehot(rb_q); alu_sel = alu_select(opcode_q); z_in = 1'b1; end
                    C_UN: begin
                        zlow_out = 1'b1;
                        rin      = (ra_q == 4'd0) ? '0 : onehot(ra_q);
                        done     = 1'b1;
                    end
                    default: ;
                endcase
                if (advance) state_d = (lat_cls == C_3OP || lat_cls == C_MD) ? S_T5 : S_IDLE;
            end
            S_T5: begin
                case (lat_cls)
                    C_3OP: begin
                        zlow_out = 1'b1;
                        rin      = (ra_q == 4'd0) ? '0 : onehot(ra_q);
                        done     = 1'b1;
                    end
                    C_MD: begin hi_in = 1'b1; lo_in = 1'b1; done = 1'b1; end
                    default: ;
                endcase
                if (advance) state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.illegal   = illegal;
    assign bus.Rout      = rout;
    assign bus.Rin       = rin;
    assign bus.PCin      = pc_in;
    assign bus.IncPC     = inc_pc;
    assign bus.MARin     = mar_in;
    assign bus.MDRin     = mdr_in;
    assign bus.Read      = read;
    assign bus.MDRout    = mdr_out;
    assign bus.IRin      = ir_in;
    assign bus.Yin       = y_in;
    assign bus.Zin       = z_in;
    assign bus.Zlowout   = zlow_out;
    assign bus.HIin      = hi_in;
    assign bus.LOin      = lo_in;
    assign {bus.AND, bus.OR, bus.ADD, bus.SUB, bus.MUL, bus.DIV, bus.SHR,
            bus.SHRA, bus.SHL, bus.ROR, bus.ROL, bus.NEG, bus.NOT} = alu_sel;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench for alu_control_sequencer: per-cycle expected output words are
// queued by the driver and checked by a negedge monitor whenever busy is high.
module tb_alu_control_sequencer;
  localparam int VW = 60;

  localparam logic [11:0] PCIN = 12'h800, INCPC = 12'h400, MARIN = 12'h200, MDRIN = 12'h100;
  localparam logic [11:0] READ = 12'h080, MDROUT = 12'h040, IRIN = 12'h020, YIN = 12'h010;
  localparam logic [11:0] ZIN = 12'h008, ZLOW = 12'h004, HIIN = 12'h002, LOIN = 12'h001;
  localparam logic [12:0] O_OR = 13'h0800, O_ADD = 13'h0400;
  localparam logic [12:0] O_MUL = 13'h0100, O_DIV = 13'h0080, O_NEG = 13'h0002, O_NOT = 13'h0001;

  logic clk;
  logic reset;
  alu_control_sequencer_if #(.NREG(16)) bus();

  alu_control_sequencer #(.NREG(16), .OPW(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [VW-1:0] exp_q[$];
  string         name_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;

  function automatic logic [VW-1:0] mk(input logic b, input logic d, input logic il,
                                       input logic [15:0] ro, input logic [15:0] ri,
                                       input logic [11:0] st, input logic [12:0] op);
    return {b, d, il, ro, ri, st, op};
  endfunction

  task automatic push(input string nm, input logic [VW-1:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic push_fetch(input string nm);
    push({nm, "_t0"}, mk(1, 0, 0, 16'h0, 16'h0, PCIN | INCPC | MARIN, 13'h0));
    push({nm, "_t1"}, mk(1, 0, 0, 16'h0, 16'h0, READ | MDRIN, 13'h0));
    push({nm, "_t2"}, mk(1, 0, 0, 16'h0, 16'h0, MDROUT | IRIN, 13'h0));
  endtask

  // driver: IR becomes valid in T3 and is scrambled from T4 on
  task automatic run(input logic [31:0] ir, input int len, input bit pulse_t1, input bit abort_t4);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 if (pulse_t1) bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 bus.IR = ir;
    @(posedge clk); #1 bus.IR = 32'h5555_5555;
    if (abort_t4) begin
      #2 reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 reset = 1'b1;
    end else begin
      repeat ((len > 5) ? len - 5 : 0) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1 bus.IR = 32'h0;
  endtask

  // monitor
  logic [VW-1:0] act;
  assign act = {bus.busy, bus.done, bus.illegal, bus.Rout, bus.Rin,
                {bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.Read, bus.MDRout, bus.IRin,
                 bus.Yin, bus.Zin, bus.Zlowout, bus.HIin, bus.LOin},
                {bus.AND, bus.OR, bus.ADD, bus.SUB, bus.MUL, bus.DIV, bus.SHR, bus.SHRA,
                 bus.SHL, bus.ROR, bus.ROL, bus.NEG, bus.NOT}};

  always @(negedge clk) begin
    logic [VW-1:0] e;
    string nm;
    n_cmp++;
    if (act[VW-1] === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_busy actual=%h required=<no step queued>", act);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s actual=%h required=%h", nm, act, e);
        end
      end
    end else if (act !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs actual=%h required=%h", act, {VW{1'b0}});
    end
  end

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.IR    = 32'h0;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step  = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // MUL ra=2 rb=6
    push_fetch("mul");
    push("mul_t3", mk(1, 0, 0, 16'h0004, 16'h0, YIN, 13'h0));
    push("mul_t4", mk(1, 0, 0, 16'h0040, 16'h0, ZIN, O_MUL));
    push("mul_t5", mk(1, 1, 0, 16'h0, 16'h0, HIIN | LOIN, 13'h0));
    run(32'h8130_0000, 6, 0, 0);

    // ADD ra=1 rb=2 rc=3, with a stray start during T1
    push_fetch("add");
    push("add_t3", mk(1, 0, 0, 16'h0004, 16'h0, YIN, 13'h0));
    push("add_t4", mk(1, 0, 0, 16'h0008, 16'h0, ZIN, O_ADD));
    push("add_t5", mk(1, 1, 0, 16'h0, 16'h0002, ZLOW, 13'h0));
    run(32'h1891_8000, 6, 1, 0);

    // NEG ra=4 rb=5
    push_fetch("neg");
    push("neg_t3", mk(1, 0, 0, 16'h0020, 16'h0, ZIN, O_NEG));
    push("neg_t4", mk(1, 1, 0, 16'h0, 16'h0010, ZLOW, 13'h0));
    run(32'h8A28_0000, 5, 0, 0);

    // illegal opcode 11111
    push_fetch("ill");
    push("ill_t3", mk(1, 0, 1, 16'h0, 16'h0, 12'h0, 13'h0));
    run(32'hF800_0000, 4, 0, 0);

    // MUL abandoned by reset in T4
    push_fetch("rst");
    push("rst_t3", mk(1, 0, 0, 16'h0004, 16'h0, YIN, 13'h0));
    run(32'h8130_0000, 6, 0, 1);

    // ADD with ra=0: write-back enable suppressed
    push_fetch("r0");
    push("r0_t3", mk(1, 0, 0, 16'h0004, 16'h0, YIN, 13'h0));
    push("r0_t4", mk(1, 0, 0, 16'h0008, 16'h0, ZIN, O_ADD));
    push("r0_t5", mk(1, 1, 0, 16'h0, 16'h0000, ZLOW, 13'h0));
    run(32'h1811_8000, 6, 0, 0);

    // OR ra=5 rb=rc=7
    push_fetch("or");
    push("or_t3", mk(1, 0, 0, 16'h0080, 16'h0, YIN, 13'h0));
    push("or_t4", mk(1, 0, 0, 16'h0080, 16'h0, ZIN, O_OR));
    push("or_t5", mk(1, 1, 0, 16'h0, 16'h0020, ZLOW, 13'h0));
    run(32'h5ABB_8000, 6, 0, 0);

    // NOT ra=15 rb=1
    push_fetch("not");
    push("not_t3", mk(1, 0, 0, 16'h0002, 16'h0, ZIN, O_NOT));
    push("not_t4", mk(1, 1, 0, 16'h0, 16'h8000, ZLOW, 13'h0));
    run(32'h9788_0000, 5, 0, 0);

    // DIV ra=3 rb=9
    push_fetch("div");
    push("div_t3", mk(1, 0, 0, 16'h0008, 16'h0, YIN, 13'h0));
    push("div_t4", mk(1, 0, 0, 16'h0200, 16'h0, ZIN, O_DIV));
    push("div_t5", mk(1, 1, 0, 16'h0, 16'h0, HIIN | LOIN, 13'h0));
    run(32'h79C8_0000, 6, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_steps actual=%0d required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
